// File: rtl/bless_eject_sink.sv
`default_nettype none
// ============================================================================
// Module   : bless_eject_sink
// Brief    : BLESS local-port ejection sink. Reassembles out-of-order flits per
//            packet in a small slot table and queues completion records in a
//            valid/ready FIFO. BLESS_EJECT_STATS_EN enables drop/misroute
//            counters and per-packet max_age tracking.
// Revision : 1.0 - initial release
// ============================================================================
module bless_eject_sink #(
    parameter int         DATA_WIDTH = 160,
    parameter logic [2:0] LOCAL_X    = 3'd0,
    parameter logic [2:0] LOCAL_Y    = 3'd0,
    parameter int         NUM_SLOTS  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  flit_valid,
    output logic                  flit_ready,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic [21:0]           cpl_data,
    output logic [15:0]           misroute_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int c_SLOT_W = $clog2(NUM_SLOTS);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    typedef enum logic [0:0] {
        SLOT_FREE    = 1'b0,
        SLOT_PARTIAL = 1'b1
    } slot_state_t;

    function automatic logic [2:0] f_popcount(input logic [6:0] m);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, m[i]};
        end
        return n;
    endfunction

    // ---------------- flit header decode ----------------
    logic [7:0] w_pkt_id;
    logic [2:0] w_dst_x, w_dst_y, w_src_x, w_src_y, w_cnt, w_seq;
    logic [5:0] w_age;

    assign w_pkt_id = flit_in[159:152];
    assign w_dst_x  = flit_in[151:149];
    assign w_dst_y  = flit_in[148:146];
    assign w_age    = flit_in[145:140];
    assign w_cnt    = flit_in[139:137];
    assign w_seq    = flit_in[136:134];
    assign w_src_x  = flit_in[133:131];
    assign w_src_y  = flit_in[130:128];

    // ---------------- slot table storage ----------------
    slot_state_t r_state     [NUM_SLOTS];
    slot_state_t w_state_nxt [NUM_SLOTS];
    logic [7:0]  r_slot_id   [NUM_SLOTS];
    logic [2:0]  r_slot_sx   [NUM_SLOTS];
    logic [2:0]  r_slot_sy   [NUM_SLOTS];
    logic [2:0]  r_slot_cnt  [NUM_SLOTS];
    logic [6:0]  r_slot_mask [NUM_SLOTS];
`ifdef BLESS_EJECT_STATS_EN
    logic [5:0]  r_slot_age  [NUM_SLOTS];
`endif

    // ---------------- completion FIFO storage ----------------
    logic [21:0]        r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full, w_pop;

    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    // Ready ignores a same-cycle pop so a push can never overflow.
    assign flit_ready = !reset && !w_full;
    assign cpl_valid  = (r_count != '0);
    assign cpl_data   = cpl_valid ? r_fifo_mem[r_rd_ptr] : 22'd0;
    assign w_pop      = cpl_valid && cpl_ready;

    // ---------------- lookup ----------------
    logic                w_accept, w_addr_ok, w_malformed;
    logic                w_hit_any, w_free_any;
    logic [c_SLOT_W-1:0] w_hit_idx, w_free_idx;

    assign w_accept    = flit_valid && flit_ready;
    assign w_addr_ok   = ({w_dst_x, w_dst_y} == {LOCAL_X, LOCAL_Y});
    assign w_malformed = (w_cnt == 3'd0) || (w_seq >= w_cnt);

    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        // Descending scan leaves the lowest matching index selected.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_state[i] == SLOT_PARTIAL && r_slot_id[i] == w_pkt_id &&
                r_slot_sx[i] == w_src_x && r_slot_sy[i] == w_src_y) begin
                w_hit_any = 1'b1;
                w_hit_idx = c_SLOT_W'(i);
            end
            if (r_state[i] == SLOT_FREE) begin
                w_free_any = 1'b1;
                w_free_idx = c_SLOT_W'(i);
            end
        end
    end

    // ---------------- flit disposition ----------------
    logic [6:0]  w_seq_bit, w_new_mask;
    logic [5:0]  w_new_age, w_single_age;
    logic        w_misroute, w_drop, w_alloc, w_update, w_complete, w_push;
    logic [21:0] w_push_rec;

    assign w_seq_bit  = 7'b000_0001 << w_seq;
    assign w_new_mask = r_slot_mask[w_hit_idx] | w_seq_bit;

`ifdef BLESS_EJECT_STATS_EN
    assign w_new_age    = (w_age > r_slot_age[w_hit_idx]) ? w_age : r_slot_age[w_hit_idx];
    assign w_single_age = w_age;
`else
    assign w_new_age    = 6'd0;
    assign w_single_age = 6'd0;
`endif

    always_comb begin
        w_misroute = 1'b0;
        w_drop     = 1'b0;
        w_alloc    = 1'b0;
        w_update   = 1'b0;
        w_complete = 1'b0;
        w_push     = 1'b0;
        w_push_rec = '0;
        if (w_accept) begin
            if (!w_addr_ok) begin
                w_misroute = 1'b1;
            end else if (w_malformed) begin
                w_drop = 1'b1;
            end else if (w_cnt == 3'd1) begin
                w_push     = 1'b1;
                w_push_rec = {w_pkt_id, w_src_x, w_src_y, w_single_age, 3'd1};
            end else if (w_hit_any) begin
                if (r_slot_mask[w_hit_idx][w_seq]) begin
                    w_drop = 1'b1;
                end else begin
                    w_update = 1'b1;
                    // Completion is judged against the flit count latched from the first flit.
                    if (f_popcount(w_new_mask) == r_slot_cnt[w_hit_idx]) begin
                        w_complete = 1'b1;
                        w_push     = 1'b1;
                        w_push_rec = {w_pkt_id, w_src_x, w_src_y, w_new_age,
                                      r_slot_cnt[w_hit_idx]};
                    end
                end
            end else if (w_free_any) begin
                w_alloc = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // ---------------- per-slot state machine ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) begin
                r_state[i] <= SLOT_FREE;
            end else begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                SLOT_FREE: begin
                    if (w_alloc && w_free_idx == c_SLOT_W'(i)) w_state_nxt[i] = SLOT_PARTIAL;
                end
                SLOT_PARTIAL: begin
                    if (w_complete && w_hit_idx == c_SLOT_W'(i)) w_state_nxt[i] = SLOT_FREE;
                end
                default: w_state_nxt[i] = SLOT_FREE;
            endcase
        end
    end

    // Slot payload is qualified by r_state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_slot_id[w_free_idx]   <= w_pkt_id;
            r_slot_sx[w_free_idx]   <= w_src_x;
            r_slot_sy[w_free_idx]   <= w_src_y;
            r_slot_cnt[w_free_idx]  <= w_cnt;
            r_slot_mask[w_free_idx] <= w_seq_bit;
        end else if (w_update) begin
            r_slot_mask[w_hit_idx] <= w_new_mask;
        end
    end

`ifdef BLESS_EJECT_STATS_EN
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_slot_age[w_free_idx] <= w_age;
        end else if (w_update) begin
            r_slot_age[w_hit_idx] <= w_new_age;
        end
    end
`endif

    // ---------------- completion FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- statistics ----------------
    logic w_unused_bits;
`ifdef BLESS_EJECT_STATS_EN
    logic [15:0] r_misroute_cnt, r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misroute_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_misroute && r_misroute_cnt != 16'hFFFF) r_misroute_cnt <= r_misroute_cnt + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF)         r_drop_cnt     <= r_drop_cnt + 16'd1;
        end
    end

    assign misroute_cnt  = r_misroute_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign w_unused_bits = ^{flit_in[127:0]};
`else
    assign misroute_cnt  = 16'd0;
    assign drop_cnt      = 16'd0;
    assign w_unused_bits = ^{flit_in[127:0], w_age, w_drop, w_misroute};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bless_eject_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_bless_eject_sink
// Brief    : Self-checking bench for bless_eject_sink with a queue-based
//            packet-level reference model; honours BLESS_EJECT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bless_eject_sink;

    localparam int         c_FD  = 4;
    localparam int         c_NS  = 4;
    localparam logic [2:0] c_LX  = 3'd3;
    localparam logic [2:0] c_LY  = 3'd4;
`ifdef BLESS_EJECT_STATS_EN
    localparam bit         c_STATS = 1'b1;
`else
    localparam bit         c_STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [159:0] flit_in = '0;
    logic         flit_valid = 1'b0;
    logic         flit_ready;
    logic         cpl_valid;
    logic         cpl_ready = 1'b1;
    logic [21:0]  cpl_data;
    logic [15:0]  misroute_cnt, drop_cnt;

    bless_eject_sink #(
        .DATA_WIDTH (160),
        .LOCAL_X    (c_LX),
        .LOCAL_Y    (c_LY),
        .NUM_SLOTS  (c_NS),
        .FIFO_DEPTH (c_FD)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .flit_in      (flit_in),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_data     (cpl_data),
        .misroute_cnt (misroute_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         v;
        logic [7:0] id;
        logic [2:0] sx, sy, cnt;
        logic [6:0] seen;
        logic [5:0] mx;
    } pkt_t;

    pkt_t        m_pkt [c_NS];
    logic [21:0] m_q [$];
    int          m_mis, m_drop;
    bit          m_rst = 1'b1;

    function automatic void model_clear();
        for (int i = 0; i < c_NS; i++) m_pkt[i].v = 1'b0;
        m_q.delete();
        m_mis  = 0;
        m_drop = 0;
    endfunction

    function automatic void bump_drop();
        if (m_drop < 65535) m_drop++;
    endfunction

    function automatic void model_flit(input logic [159:0] f);
        logic [7:0] id;
        logic [2:0] dx, dy, cnt, seq, sx, sy;
        logic [5:0] age;
        int hit, fr;
        id = f[159:152]; dx = f[151:149]; dy = f[148:146]; age = f[145:140];
        cnt = f[139:137]; seq = f[136:134]; sx = f[133:131]; sy = f[130:128];
        if (dx != c_LX || dy != c_LY) begin
            if (m_mis < 65535) m_mis++;
            return;
        end
        if (cnt == 0 || seq >= cnt) begin
            bump_drop();
            return;
        end
        if (cnt == 1) begin
            m_q.push_back({id, sx, sy, (c_STATS ? age : 6'd0), 3'd1});
            return;
        end
        hit = -1;
        fr  = -1;
        for (int i = 0; i < c_NS; i++) begin
            if (hit < 0 && m_pkt[i].v && m_pkt[i].id == id && m_pkt[i].sx == sx && m_pkt[i].sy == sy) hit = i;
            if (fr < 0 && !m_pkt[i].v) fr = i;
        end
        if (hit >= 0) begin
            if (m_pkt[hit].seen[seq]) begin
                bump_drop();
            end else begin
                m_pkt[hit].seen[seq] = 1'b1;
                if (age > m_pkt[hit].mx) m_pkt[hit].mx = age;
                if ($countones(m_pkt[hit].seen) == m_pkt[hit].cnt) begin
                    m_q.push_back({id, sx, sy, (c_STATS ? m_pkt[hit].mx : 6'd0), m_pkt[hit].cnt});
                    m_pkt[hit].v = 1'b0;
                end
            end
        end else if (fr >= 0) begin
            m_pkt[fr].v    = 1'b1;
            m_pkt[fr].id   = id;
            m_pkt[fr].sx   = sx;
            m_pkt[fr].sy   = sy;
            m_pkt[fr].cnt  = cnt;
            m_pkt[fr].seen = 7'd0;
            m_pkt[fr].seen[seq] = 1'b1;
            m_pkt[fr].mx   = age;
        end else begin
            bump_drop();
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [159:0] mk(input int id, input int dx, input int dy, input int age,
                                        input int cnt, input int seq, input int sx, input int sy);
        logic [159:0] r;
        r[159:152] = id[7:0];
        r[151:149] = dx[2:0];
        r[148:146] = dy[2:0];
        r[145:140] = age[5:0];
        r[139:137] = cnt[2:0];
        r[136:134] = seq[2:0];
        r[133:131] = sx[2:0];
        r[130:128] = sy[2:0];
        r[127:0]   = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Compare outputs against the model, then drive one cycle of stimulus.
    task automatic step(input logic rst, input logic v, input logic [159:0] f, input logic rdy);
        bit acc, pop;
        @(negedge clk);
        check("flit_ready", {31'd0, flit_ready}, {31'd0, (!m_rst && m_q.size() < c_FD)});
        check("cpl_valid", {31'd0, cpl_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) check("cpl_data", {10'd0, cpl_data}, {10'd0, m_q[0]});
        check("misroute_cnt", {16'd0, misroute_cnt}, c_STATS ? m_mis : 0);
        check("drop_cnt", {16'd0, drop_cnt}, c_STATS ? m_drop : 0);
        reset      = rst;
        flit_valid = v;
        flit_in    = f;
        cpl_ready  = rdy;
        m_rst      = rst;
        if (rst) begin
            model_clear();
        end else begin
            acc = v && (m_q.size() < c_FD);
            pop = (m_q.size() != 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (acc) model_flit(f);
        end
    endtask

    task automatic send(input logic [159:0] f, input logic rdy);
        step(1'b0, 1'b1, f, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        model_clear();
        // Reset state
        step(1'b1, 1'b0, '0, 1'b1);
        check("cpl_data_rst", {10'd0, cpl_data}, 32'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        idle(2, 1'b1);

        // Single-flit packet
        send(mk(8'h02, 3, 4, 5, 1, 0, 0, 0), 1'b1);
        idle(2, 1'b1);

        // Out-of-order three-flit packet
        send(mk(8'h04, 3, 4, 1, 3, 2, 1, 2), 1'b1);
        send(mk(8'h04, 3, 4, 7, 3, 0, 1, 2), 1'b1);
        send(mk(8'h04, 3, 4, 3, 3, 1, 1, 2), 1'b1);
        idle(2, 1'b1);

        // Misroute and malformed headers
        send(mk(8'h06, 7, 7, 2, 2, 0, 0, 0), 1'b1);
        send(mk(8'h07, 3, 4, 2, 0, 0, 0, 0), 1'b1);
        send(mk(8'h08, 3, 4, 2, 2, 2, 0, 0), 1'b1);
        idle(1, 1'b1);

        // Duplicate sequence number
        send(mk(8'h05, 3, 4, 4, 2, 0, 2, 1), 1'b1);
        send(mk(8'h05, 3, 4, 9, 2, 0, 2, 1), 1'b1);
        send(mk(8'h05, 3, 4, 6, 2, 1, 2, 1), 1'b1);
        idle(2, 1'b1);

        // Slot exhaustion, then free a slot and retry the rejected packet
        for (int i = 0; i < 5; i++) send(mk(8'h10 + i, 3, 4, i, 2, 0, 5, 5), 1'b1);
        send(mk(8'h10, 3, 4, 20, 2, 1, 5, 5), 1'b1);
        send(mk(8'h14, 3, 4, 11, 2, 0, 5, 5), 1'b1);
        for (int i = 1; i < 5; i++) send(mk(8'h10 + i, 3, 4, 30 + i, 2, 1, 5, 5), 1'b1);
        idle(6, 1'b1);

        // FIFO backpressure: fill, hold, then a flit offered while full
        for (int i = 0; i < 4; i++) send(mk(8'h20 + i, 3, 4, i, 1, 0, 3, 3), 1'b0);
        for (int i = 0; i < 3; i++) send(mk(8'h30, 3, 4, 1, 1, 0, 3, 3), 1'b0);
        // Pop while full: the offered flit must still be refused this cycle
        send(mk(8'h31, 3, 4, 1, 1, 0, 3, 3), 1'b1);
        send(mk(8'h32, 3, 4, 1, 2, 0, 3, 3), 1'b0);
        send(mk(8'h33, 3, 4, 1, 2, 0, 3, 3), 1'b0);
        // Reset mid-operation discards FIFO and partial packets
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("cpl_data_rst2", {10'd0, cpl_data}, 32'd0);
        send(mk(8'h32, 3, 4, 1, 2, 1, 3, 3), 1'b1);
        idle(3, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int cnt, seq, dx, dy;
            logic rst, v, rdy;
            cnt = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
            if (cnt == 0 || $urandom_range(0, 9) == 0) seq = $urandom_range(0, 7);
            else seq = $urandom_range(0, cnt - 1);
            dx  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 3;
            dy  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 4;
            rst = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(rst, v, mk($urandom_range(0, 5), dx, dy, $urandom_range(0, 63), cnt, seq,
                            $urandom_range(0, 1), $urandom_range(0, 1)), rdy);
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
